// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter sharing one req/gnt/rvalid memory port.
// An in-order FIFO of master IDs routes each response back to its issuer.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m0_req_i,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_gnt_o,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    output logic                    m0_error_o,
    input  logic                    m1_req_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_gnt_o,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    m1_error_o,
    output logic                    mem_req_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    mem_error_i,
    output logic                    spurious_o
);

    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OUTSTANDING);

    logic               prio_r;
    logic               lock_v_r;
    logic               lock_id_r;
    logic               spurious_r;
    logic [CNT_W-1:0]   count_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic               fifo_r [OUTSTANDING];

    logic sel_s;
    logic sel_req_s;
    logic space_s;
    logic req_s;
    logic push_s;
    logic pop_s;
    logic head_s;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    // Master selection and downstream space; a stalled request stays locked to its master
    always_comb begin
        sel_s = prio_r;
        if (lock_v_r) begin
            sel_s = lock_id_r;
        end else if (m0_req_i && !m1_req_i) begin
            sel_s = 1'b0;
        end else if (m1_req_i && !m0_req_i) begin
            sel_s = 1'b1;
        end else begin
            sel_s = prio_r;
        end
        sel_req_s = sel_s ? m1_req_i : m0_req_i;
        space_s   = (count_r < CNT_MAX) || (mem_rvalid_i && (count_r != {CNT_W{1'b0}}));
        req_s     = space_s && sel_req_s;
        push_s    = req_s && mem_gnt_i;
        pop_s     = mem_rvalid_i && (count_r != {CNT_W{1'b0}});
        head_s    = fifo_r[rd_ptr_r];
    end

    // Request field mux, zeroed whenever no request is forwarded
    always_comb begin
        mem_addr_o  = {ADDR_WIDTH{1'b0}};
        mem_we_o    = 1'b0;
        mem_be_o    = {(DATA_WIDTH/8){1'b0}};
        mem_wdata_o = {DATA_WIDTH{1'b0}};
        if (req_s) begin
            mem_addr_o  = sel_s ? m1_addr_i  : m0_addr_i;
            mem_we_o    = sel_s ? m1_we_i    : m0_we_i;
            mem_be_o    = sel_s ? m1_be_i    : m0_be_i;
            mem_wdata_o = sel_s ? m1_wdata_i : m0_wdata_i;
        end else begin
            mem_addr_o  = {ADDR_WIDTH{1'b0}};
        end
    end

    assign mem_req_o   = req_s;
    assign m0_gnt_o    = push_s && !sel_s;
    assign m1_gnt_o    = push_s && sel_s;
    assign m0_rvalid_o = pop_s && !head_s;
    assign m1_rvalid_o = pop_s && head_s;
    assign m0_error_o  = mem_error_i && m0_rvalid_o;
    assign m1_error_o  = mem_error_i && m1_rvalid_o;
    assign m0_rdata_o  = mem_rdata_i;
    assign m1_rdata_o  = mem_rdata_i;
    assign spurious_o  = spurious_r;

    // ID FIFO storage, pointers and occupancy count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r  <= {CNT_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            for (int i = 0; i < OUTSTANDING; i++) begin
                fifo_r[i] <= 1'b0;
            end
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= sel_s;
                wr_ptr_r         <= ptr_next(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Round-robin pointer, stall lock and sticky spurious-response flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_r     <= 1'b0;
            lock_v_r   <= 1'b0;
            lock_id_r  <= 1'b0;
            spurious_r <= 1'b0;
        end else begin
            if (push_s) begin
                prio_r   <= !sel_s;
                lock_v_r <= 1'b0;
            end else if (req_s) begin
                lock_v_r  <= 1'b1;
                lock_id_r <= sel_s;
            end else begin
                lock_v_r <= lock_v_r;
            end
            if (mem_rvalid_i && (count_r == {CNT_W{1'b0}})) begin
                spurious_r <= 1'b1;
            end else begin
                spurious_r <= spurious_r;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a response scoreboard is filled by the
// stimulus and drained by an independent monitor that watches master rvalids.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr;
    logic        m0_we, m1_we;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_error, m1_error;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid, mem_error, spurious;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be),
        .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
        .m0_rdata_o(m0_rdata), .m0_error_o(m0_error),
        .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be),
        .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
        .m1_rdata_o(m1_rdata), .m1_error_o(m1_error),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .mem_error_i(mem_error), .spurious_o(spurious)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    // Response monitor: every master rvalid must match the oldest expected response
    always @(negedge clk) begin
        exp_t e;
        if (m0_rvalid || m1_rvalid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rvalid_route", {30'd0, m1_rvalid, m0_rvalid}, (e.id == 1) ? 32'd2 : 32'd1);
                chk("rdata", (e.id == 1) ? m1_rdata : m0_rdata, e.data);
                chk("error_route", {30'd0, m1_error, m0_error},
                    !e.err ? 32'd0 : ((e.id == 1) ? 32'd2 : 32'd1));
            end
        end else if (exp_q.size() != 0) begin
            chk("missing_rvalid", 32'd0, 32'd1);
            exp_q.delete();
        end
    end

    // One cycle: drive inputs after the edge, check combinational outputs at negedge
    task automatic cyc(input logic r0, input logic r1, input logic g, input logic rv,
                       input logic [31:0] rd, input logic er, input logic [1:0] eg,
                       input int es, input int exp_id, input logic esp, input string nm);
        exp_t e;
        m0_req = r0; m1_req = r1; mem_gnt = g;
        mem_rvalid = rv; mem_rdata = rd; mem_error = er;
        if (exp_id >= 0) begin
            e.id = exp_id; e.data = rd; e.err = er;
            exp_q.push_back(e);
        end
        @(negedge clk);
        chk({nm, ".gnt"}, {30'd0, m1_gnt, m0_gnt}, {30'd0, eg});
        chk({nm, ".req"}, {31'd0, mem_req}, (es >= 0) ? 32'd1 : 32'd0);
        chk({nm, ".addr"}, mem_addr, (es == 0) ? m0_addr : (es == 1) ? m1_addr : 32'd0);
        chk({nm, ".wdata"}, mem_wdata, (es == 0) ? m0_wdata : (es == 1) ? m1_wdata : 32'd0);
        chk({nm, ".we_be"}, {27'd0, mem_we, mem_be},
            (es == 0) ? {27'd0, m0_we, m0_be} : (es == 1) ? {27'd0, m1_we, m1_be} : 32'd0);
        chk({nm, ".spurious"}, {31'd0, spurious}, {31'd0, esp});
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0; mem_gnt = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = 32'd0; mem_error = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst.gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        chk("rst.rvalid_err", {28'd0, m1_rvalid, m0_rvalid, m1_error, m0_error}, 32'd0);
        chk("rst.req", {31'd0, mem_req}, 32'd0);
        chk("rst.fields", mem_addr | mem_wdata | {27'd0, mem_we, mem_be}, 32'd0);
        chk("rst.spurious", {31'd0, spurious}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        m0_addr = 32'h0010_0000; m0_we = 1'b0; m0_be = 4'hF; m0_wdata = 32'h0000_0000;
        m1_addr = 32'h0020_0040; m1_we = 1'b1; m1_be = 4'h3; m1_wdata = 32'hCAFE_0001;

        // Contention: strict alternation starting at M0, responses one cycle later
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 1'b1, 1'b1, k > 0, 32'hA000_0000 + k, 1'b0,
                (k % 2 == 0) ? 2'b01 : 2'b10, k % 2, (k > 0) ? (k - 1) % 2 : -1, 1'b0, "cont");
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'hA000_0008, 1'b0, 2'b00, -1, 1, 1'b0, "cont_tail");

        // Hold under stall, then error routing and a spurious response
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 2'b00, 1, -1, 1'b0, "hold0");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 2'b00, 1, -1, 1'b0, "hold1");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 2'b00, 1, -1, 1'b0, "hold2");
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 2'b10, 1, -1, 1'b0, "hold_g1");
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'hBEEF_0001, 1'b1, 2'b01, 0, 1, 1'b0, "hold_g0_err");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hBEEF_0002, 1'b0, 2'b00, -1, 0, 1'b0, "resp_m0");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_0000, 1'b0, 2'b00, -1, -1, 1'b0, "spur");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 2'b00, -1, -1, 1'b1, "spur_held1");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 2'b00, -1, -1, 1'b1, "spur_held2");

        // Full FIFO: requests blocked at two outstanding, reopened by rvalid
        do_reset();
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 2'b01, 0, -1, 1'b0, "full_g0");
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 2'b10, 1, -1, 1'b0, "full_g1");
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 2'b00, -1, -1, 1'b0, "full_blk0");
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 2'b00, -1, -1, 1'b0, "full_blk1");
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_1111, 1'b0, 2'b01, 0, 0, 1'b0, "full_rv_g0");
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_2222, 1'b0, 2'b10, 1, 1, 1'b0, "full_rv_g1");
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 2'b00, -1, -1, 1'b0, "full_cnt2");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3333, 1'b0, 2'b00, -1, 0, 1'b0, "full_drain0");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_4444, 1'b0, 2'b00, -1, 1, 1'b0, "full_drain1");

        // Reset with two transactions in flight
        do_reset();
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 2'b01, 0, -1, 1'b0, "rst_g0");
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 2'b10, 1, -1, 1'b0, "rst_g1");
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_5555, 1'b0, 2'b00, -1, -1, 1'b0, "late0");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_6666, 1'b0, 2'b00, -1, -1, 1'b1, "late1");
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 2'b01, 0, -1, 1'b1, "post_g0");
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_7777, 1'b0, 2'b10, 1, 0, 1'b1, "post_g1");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_8888, 1'b0, 2'b00, -1, 1, 1'b1, "post_drain");

        // Single master: write then read back through the port
        do_reset();
        m0_we = 1'b1; m0_wdata = 32'h1234_ABCD;
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 2'b01, 0, -1, 1'b0, "wr_m0");
        m0_we = 1'b0; m0_wdata = 32'h0000_0000;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 2'b00, -1, 0, 1'b0, "wr_ack");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 2'b01, 0, -1, 1'b0, "rd_m0");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_ABCD, 1'b0, 2'b00, -1, 0, 1'b0, "rd_data");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 2'b00, -1, -1, 1'b0, "idle");

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
